divider_extern_initiator: RTL and testbench
===========================================

# divider_extern_initiator

Initiator-side counterpart of the divider user extern: accepts divide requests from a ready/valid stream, issues them as single-cycle `user_extern_out_valid` pulses toward the extern, and collects the returned `user_extern_in` words into a response FIFO presented as a ready/valid stream. The extern interface has no backpressure, so the block enforces credit-based flow control: no request is issued unless response buffer space is reserved for it. It sits on the core side of the extern boundary, and also serves as the standalone exerciser for `divider_extern`.

## Interface
Parameters:
- `DEPTH`, 8: response FIFO depth and maximum in-flight requests; power of two, ≥2.
- `TIMEOUT`, 256: cycles without a response while requests are outstanding before `timeout_err` sets; ≥1.

Ports:
- `aclk` in 1: single clock; all logic is on the rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_dividend` in 32, `req_divisor` in 32: operands, unsigned.
- `user_extern_out_valid` out 1: one-cycle issue pulse to the extern.
- `user_extern_out` out 64: `{dividend[63:32], divisor[31:0]}`.
- `user_extern_in_valid` in 1: one-cycle response pulse from the extern.
- `user_extern_in` in 64: `{quotient[63:32], remainder[31:0]}`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_quotient` out 32, `rsp_remainder` out 32: head-of-FIFO response.
- `outstanding` out $clog2(DEPTH)+1: issued requests not yet returned.
- `timeout_err` out 1, `proto_err` out 1: sticky error flags.
- `err_clear` in 1: synchronous clear of both sticky flags.

## Operation
- Credit: `used = outstanding + fifo_count`. `req_ready = (used < DEPTH)`, combinational from registered state only, never from `req_valid`.
- Issue: on `req_valid && req_ready`, the operands are registered into `user_extern_out`, and `user_extern_out_valid` pulses high for exactly one cycle in the next cycle. Back-to-back requests give back-to-back pulses. `user_extern_out` holds its last value when not valid.
- `outstanding`: +1 on issue, −1 on `user_extern_in_valid`, unchanged when both occur. It increments in the same cycle the pulse is driven.
- Response capture: every `user_extern_in_valid` with `outstanding > 0` writes into the FIFO. Responses are in order; no tags are used.
- Spurious response (`user_extern_in_valid` while `outstanding == 0`): the word is dropped, `proto_err` sets, and counters are unchanged.
- Output: `rsp_valid = !fifo_empty`. Data is taken from the FIFO head and pops on `rsp_valid && rsp_ready`. A push to an empty FIFO is visible the next cycle. Simultaneous push and pop are supported when full or empty.
- Timeout: the wait counter clears on any response or when `outstanding == 0`, and otherwise increments each cycle. When it reaches `TIMEOUT`, `timeout_err` sets and the counter saturates. Request issue continues.
- `err_clear` clears both flags. If an error condition occurs in the same cycle, the set wins.
- Division by zero is not special-cased; the extern's result is passed through unchanged.

## Timing
- Reset values: `req_ready` 1 (follows from `used` = 0 after reset), `user_extern_out_valid` 0, `user_extern_out` 0, `rsp_valid` 0, `rsp_quotient`/`rsp_remainder` 0, `outstanding` 0, `timeout_err` 0, `proto_err` 0. The FIFO is emptied and the wait counter cleared.
- Latency from request handshake to issue pulse: 1 cycle.
- Latency from `user_extern_in_valid` to `rsp_valid`: 1 cycle.
- Throughput: one request per cycle when credits are available.
- Reset mid-operation: all in-flight requests are forgotten. A response arriving after reset release is treated as spurious and sets `proto_err`.
- Full credit: with `used == DEPTH`, `req_ready` is 0. A pop or a response in cycle N does not raise `req_ready` until cycle N+1.

## Structure
- Package `divider_extern_pkg`:
  - `OPERAND_W` = 32 and `EXTERN_W` = 64.
  - Packed structs `div_req_t {dividend, divisor}` and `div_rsp_t {quotient, remainder}`, both 64 bits and matching the bit layouts above.
  - This package is shared with `divider_extern`.
- Sub-module `extern_rsp_fifo`: synchronous FIFO with parameter `DEPTH`, width `EXTERN_W`, and a `count` output.
- The top level holds the credit logic, issue register, outstanding counter, timeout counter and error flags.

## Test plan
- Single request 100/7, with the extern model returning after 3 cycles: one `user_extern_out_valid` pulse carrying 0x00000064_00000007, then the response quotient 14 and remainder 2, with `outstanding` returning 1→0.
- Eight back-to-back requests with `DEPTH` = 8 and `rsp_ready` held 0: 8 pulses are issued, `req_ready` drops after the 8th, and a 9th request is held until one pop occurs; the FIFO never overflows.
- Response and new issue in the same cycle with `outstanding` = 3: `outstanding` stays 3, and the response appears on `rsp_*` the next cycle.
- No responses for 256 cycles after one issue: `timeout_err` rises at cycle 256 and stays set; `err_clear` drops it while a late response is still accepted.
- `user_extern_in_valid` pulse with `outstanding` = 0: `proto_err` is 1, `rsp_valid` stays 0, and the counters are unchanged.
- Assert `aresetn` low with 4 requests outstanding: all outputs return to their reset values asynchronously, and `req_ready` is 1 after release.

Source files
------------

// File: rtl/divider_extern_pkg.sv
// Shared types for the divider extern boundary: operand widths and the
// 64-bit request/response word layouts used on both sides of the extern.
package divider_extern_pkg;

    localparam int OPERAND_W = 32;
    localparam int EXTERN_W  = 64;

    // Request word: dividend in the upper half, divisor in the lower half.
    typedef struct packed {
        logic [OPERAND_W-1:0] dividend;
        logic [OPERAND_W-1:0] divisor;
    } div_req_t;

    // Response word: quotient in the upper half, remainder in the lower half.
    typedef struct packed {
        logic [OPERAND_W-1:0] quotient;
        logic [OPERAND_W-1:0] remainder;
    } div_rsp_t;

    // Builds a request word from its two operands.
    function automatic div_req_t make_req(input logic [OPERAND_W-1:0] dividend,
                                          input logic [OPERAND_W-1:0] divisor);
        div_req_t r;
        r.dividend = dividend;
        r.divisor  = divisor;
        return r;
    endfunction

endpackage

// File: rtl/extern_rsp_fifo.sv
// Response buffer for words coming back from the extern. Head data is read
// straight from storage, so a push into an empty FIFO shows on the next cycle.
// Push and pop may coincide in any fill state, including full and empty.
module extern_rsp_fifo
    import divider_extern_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  push,
    input  logic [EXTERN_W-1:0]   push_data,
    input  logic                  pop,
    output logic [EXTERN_W-1:0]   head,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [EXTERN_W-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                full;
    logic                do_write;
    logic                do_read;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if
    // the head leaves in the same cycle, freeing the slot it writes into.
    assign do_read  = pop && !empty;
    assign do_write = push && (!full || pop);

    assign head = mem[rd_ptr];

    // Storage is cleared on reset so the response outputs read as zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PW'(1);
            if (do_read)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy tracks writes minus reads; both together leave it unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else begin
            case ({do_write, do_read})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/divider_extern_initiator.sv
// Core-side initiator for the divider extern. Requests are only issued when a
// response slot is guaranteed (outstanding + buffered < DEPTH), because the
// extern cannot be stalled once it answers. Also tracks response silence and
// responses that arrive with nothing in flight.
module divider_extern_initiator
    import divider_extern_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPERAND_W-1:0]   req_dividend,
    input  logic [OPERAND_W-1:0]   req_divisor,
    output logic                   user_extern_out_valid,
    output logic [EXTERN_W-1:0]    user_extern_out,
    input  logic                   user_extern_in_valid,
    input  logic [EXTERN_W-1:0]    user_extern_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [OPERAND_W-1:0]   rsp_quotient,
    output logic [OPERAND_W-1:0]   rsp_remainder,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   timeout_err,
    output logic                   proto_err,
    input  logic                   err_clear
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT);

    logic             issue;
    logic             rsp_accept;
    logic             spurious;
    logic [CNT_W:0]   used;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [EXTERN_W-1:0] fifo_head;
    div_rsp_t         head_rsp;
    div_req_t         req_q;
    logic [TW-1:0]    wait_cnt;
    logic [TW-1:0]    wait_next;
    logic             wait_clear;
    logic             timeout_hit;

    // One extra bit on used so the sum can never wrap before the compare.
    assign used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req_ready = (used < (CNT_W+1)'(DEPTH));
    assign issue     = req_valid && req_ready;

    // Responses only count when something is in flight; otherwise they are
    // dropped and flagged as a protocol error.
    assign rsp_accept = user_extern_in_valid && (outstanding != '0);
    assign spurious   = user_extern_in_valid && (outstanding == '0);

    extern_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (rsp_accept),
        .push_data (user_extern_in),
        .pop       (rsp_valid && rsp_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_rsp      = div_rsp_t'(fifo_head);
    assign rsp_valid     = !fifo_empty;
    assign rsp_quotient  = head_rsp.quotient;
    assign rsp_remainder = head_rsp.remainder;
    assign user_extern_out = req_q;

    // Issue register: capture operands on handshake, pulse valid next cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_q                 <= '0;
            user_extern_out_valid <= 1'b0;
        end else begin
            user_extern_out_valid <= issue;
            if (issue) begin
                req_q <= make_req(req_dividend, req_divisor);
            end
        end
    end

    // In-flight count moves with the issue pulse and with accepted responses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else begin
            case ({issue, rsp_accept})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Silence timer: counts idle cycles while waiting, saturates at the limit,
    // and reports only the cycle it reaches the limit so a clear can stick.
    always_comb begin
        wait_clear  = user_extern_in_valid || (outstanding == '0);
        wait_next   = wait_cnt;
        timeout_hit = 1'b0;
        if (wait_clear) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_next   = wait_cnt + TW'(1);
            timeout_hit = (wait_cnt == WAIT_MAX - TW'(1));
        end
    end

    // Silence timer register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (timeout_hit)    timeout_err <= 1'b1;
            else if (err_clear) timeout_err <= 1'b0;
            if (spurious)       proto_err   <= 1'b1;
            else if (err_clear) proto_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divider_extern_initiator.sv
// Directed bench for divider_extern_initiator. The bench plays the extern:
// it records every accepted request and answers in order with a reference
// divide. A table of hand-computed vectors covers the basic round trip.
module tb_divider_extern_initiator;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 256;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor = '0;
    logic        user_extern_out_valid;
    logic [63:0] user_extern_out;
    logic        user_extern_in_valid = 1'b0;
    logic [63:0] user_extern_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic [3:0]  outstanding;
    logic        timeout_err;
    logic        proto_err;
    logic        err_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;

    logic [63:0] sent_q[$];
    logic [63:0] inflight_q[$];
    logic [63:0] rsp_exp_q[$];

    typedef struct {
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic [31:0] quotient;
        logic [31:0] remainder;
    } vec_t;

    vec_t vecs[6];

    divider_extern_initiator #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_dividend          (req_dividend),
        .req_divisor           (req_divisor),
        .user_extern_out_valid (user_extern_out_valid),
        .user_extern_out       (user_extern_out),
        .user_extern_in_valid  (user_extern_in_valid),
        .user_extern_in        (user_extern_in),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_quotient          (rsp_quotient),
        .rsp_remainder         (rsp_remainder),
        .outstanding           (outstanding),
        .timeout_err           (timeout_err),
        .proto_err             (proto_err),
        .err_clear             (err_clear)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 64'(actual), 64'(expected));
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference divider; divide by zero returns all-ones quotient and the dividend.
    function automatic logic [63:0] divModel(input logic [63:0] op);
        logic [31:0] a;
        logic [31:0] b;
        a = op[63:32];
        b = op[31:0];
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Issue-side monitor: every pulse must carry the next accepted request.
    always @(negedge aclk) begin
        if (aresetn && user_extern_out_valid) begin
            pulse_count++;
            if (sent_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL issue_unexpected actual=0x%0h expected=no_pulse", user_extern_out);
            end else begin
                checkOutput("issue_data", user_extern_out, sent_q.pop_front());
            end
        end
    end

    // Drive one request and wait (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        int budget;
        budget = 0;
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        while (!req_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_wait actual=ready_low expected=ready_high");
        end else begin
            tick();
            sent_q.push_back({a, b});
            inflight_q.push_back({a, b});
        end
        req_valid = 1'b0;
    endtask

    // Answer the oldest in-flight request for one cycle.
    task automatic sendResponse();
        logic [63:0] r;
        if (inflight_q.size() == 0) return;
        r = divModel(inflight_q.pop_front());
        rsp_exp_q.push_back(r);
        user_extern_in_valid = 1'b1;
        user_extern_in       = r;
        tick();
        user_extern_in_valid = 1'b0;
    endtask

    // Check the head response against the oldest expected one, then pop it.
    task automatic popResponse(input string name);
        checkBit({name, "_valid"}, rsp_valid, 1'b1);
        if (rsp_exp_q.size() != 0)
            checkOutput({name, "_data"}, {rsp_quotient, rsp_remainder}, rsp_exp_q.pop_front());
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;

        vecs[0] = '{32'd100,        32'd7,     32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,     32'hFFFF_FFFF,  32'd0};
        vecs[2] = '{32'd12345,      32'd12345, 32'd1,          32'd0};
        vecs[3] = '{32'd5,          32'd9,     32'd0,          32'd5};
        vecs[4] = '{32'h8000_0000,  32'd3,     32'd715827882,  32'd2};
        vecs[5] = '{32'd1000,       32'd0,     32'hFFFF_FFFF,  32'd1000};

        // Reset values.
        #2;
        checkBit("rst_req_ready", req_ready, 1'b1);
        checkBit("rst_out_valid", user_extern_out_valid, 1'b0);
        checkOutput("rst_out", user_extern_out, 64'd0);
        checkBit("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_data", {rsp_quotient, rsp_remainder}, 64'd0);
        checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
        checkBit("rst_timeout", timeout_err, 1'b0);
        checkBit("rst_proto", proto_err, 1'b0);
        #10;
        aresetn = 1'b1;
        tick();

        // Table: single request, extern answers three cycles later.
        for (int i = 0; i < 6; i++) begin
            p0 = pulse_count;
            applyStimulus(vecs[i].dividend, vecs[i].divisor);
            checkBit("vec_pulse_hi", user_extern_out_valid, 1'b1);
            checkOutput("vec_out_word", user_extern_out, {vecs[i].dividend, vecs[i].divisor});
            checkOutput("vec_outstanding_1", 64'(outstanding), 64'd1);
            tick();
            checkBit("vec_pulse_single", user_extern_out_valid, 1'b0);
            tick();
            checkOutput("vec_pulse_count", 64'(pulse_count), 64'(p0 + 1));
            sendResponse();
            rsp_exp_q.delete();
            checkBit("vec_rsp_valid", rsp_valid, 1'b1);
            checkOutput("vec_quotient", 64'(rsp_quotient), 64'(vecs[i].quotient));
            checkOutput("vec_remainder", 64'(rsp_remainder), 64'(vecs[i].remainder));
            checkOutput("vec_outstanding_0", 64'(outstanding), 64'd0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checkBit("vec_rsp_popped", rsp_valid, 1'b0);
        end

        // Eight back-to-back requests fill every credit.
        p0 = pulse_count;
        for (int i = 0; i < 8; i++) applyStimulus(32'(1000 + i * 37), 32'(i + 3));
        checkBit("b2b_ready_low", req_ready, 1'b0);
        checkOutput("b2b_outstanding", 64'(outstanding), 64'd8);
        tick();
        tick();
        checkOutput("b2b_pulses", 64'(pulse_count), 64'(p0 + 8));
        for (int i = 0; i < 8; i++) sendResponse();
        checkOutput("b2b_outstanding_0", 64'(outstanding), 64'd0);
        checkBit("b2b_full_ready_low", req_ready, 1'b0);

        // A ninth request is held until one response is popped.
        req_valid    = 1'b1;
        req_dividend = 32'd77;
        req_divisor  = 32'd5;
        repeat (3) tick();
        checkBit("hold_ready_low", req_ready, 1'b0);
        checkOutput("hold_no_pulse", 64'(pulse_count), 64'(p0 + 8));
        popResponse("b2b_pop");
        checkBit("pop_then_ready", req_ready, 1'b1);
        tick();
        sent_q.push_back({32'd77, 32'd5});
        inflight_q.push_back({32'd77, 32'd5});
        req_valid = 1'b0;
        checkOutput("ninth_outstanding", 64'(outstanding), 64'd1);
        checkBit("ninth_ready_low", req_ready, 1'b0);
        tick();
        checkOutput("ninth_pulse", 64'(pulse_count), 64'(p0 + 9));
        sendResponse();
        for (int i = 0; i < 8; i++) popResponse("b2b_drain");
        checkBit("b2b_empty", rsp_valid, 1'b0);

        // Response and new issue in the same cycle with three in flight.
        for (int i = 0; i < 3; i++) applyStimulus(32'(50 * (i + 1)), 32'd4);
        checkOutput("same_outstanding_3", 64'(outstanding), 64'd3);
        req_valid    = 1'b1;
        req_dividend = 32'd600;
        req_divisor  = 32'd25;
        sendResponse();
        req_valid = 1'b0;
        sent_q.push_back({32'd600, 32'd25});
        inflight_q.push_back({32'd600, 32'd25});
        checkOutput("same_outstanding_kept", 64'(outstanding), 64'd3);
        checkBit("same_pulse", user_extern_out_valid, 1'b1);
        popResponse("same_rsp");
        for (int i = 0; i < 3; i++) sendResponse();
        for (int i = 0; i < 3; i++) popResponse("same_drain");

        // Silence timeout after one issue, clear, then a late response.
        applyStimulus(32'd9, 32'd3);
        repeat (255) tick();
        checkBit("timeout_before", timeout_err, 1'b0);
        tick();
        checkBit("timeout_at_limit", timeout_err, 1'b1);
        repeat (5) tick();
        checkBit("timeout_sticky", timeout_err, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkBit("timeout_cleared", timeout_err, 1'b0);
        repeat (3) tick();
        checkBit("timeout_stays_clear", timeout_err, 1'b0);
        sendResponse();
        checkOutput("late_outstanding", 64'(outstanding), 64'd0);
        popResponse("late_rsp");

        // Spurious response with nothing in flight.
        user_extern_in_valid = 1'b1;
        user_extern_in       = 64'hDEAD_BEEF_0000_0001;
        tick();
        user_extern_in_valid = 1'b0;
        checkBit("proto_set", proto_err, 1'b1);
        checkBit("proto_no_rsp", rsp_valid, 1'b0);
        checkOutput("proto_outstanding", 64'(outstanding), 64'd0);
        checkBit("proto_ready", req_ready, 1'b1);
        err_clear            = 1'b1;
        user_extern_in_valid = 1'b1;
        tick();
        user_extern_in_valid = 1'b0;
        checkBit("proto_set_wins", proto_err, 1'b1);
        tick();
        err_clear = 1'b0;
        checkBit("proto_cleared", proto_err, 1'b0);

        // Asynchronous reset with four requests in flight.
        for (int i = 0; i < 4; i++) applyStimulus(32'(200 + i), 32'd6);
        checkOutput("prerst_outstanding", 64'(outstanding), 64'd4);
        #2;
        aresetn = 1'b0;
        #1;
        sent_q.delete();
        inflight_q.delete();
        rsp_exp_q.delete();
        checkOutput("arst_outstanding", 64'(outstanding), 64'd0);
        checkBit("arst_out_valid", user_extern_out_valid, 1'b0);
        checkOutput("arst_out", user_extern_out, 64'd0);
        checkBit("arst_rsp_valid", rsp_valid, 1'b0);
        tick();
        aresetn = 1'b1;
        tick();
        checkBit("postrst_ready", req_ready, 1'b1);
        user_extern_in_valid = 1'b1;
        user_extern_in       = 64'h0000_0021_0000_0002;
        tick();
        user_extern_in_valid = 1'b0;
        checkBit("postrst_proto", proto_err, 1'b1);
        checkBit("postrst_no_rsp", rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
